// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports, one
// synchronous write port, optional hardwired-zero register 0.
module register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we3,
    input  logic [ADDR_WIDTH-1:0] wa3,
    input  logic [DATA_WIDTH-1:0] wd3,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];

    logic wa_zero;
    logic ra1_zero;
    logic ra2_zero;

    assign wa_zero  = (ZERO_REG != 0) && (wa3 == '0);
    assign ra1_zero = (ZERO_REG != 0) && (ra1 == '0);
    assign ra2_zero = (ZERO_REG != 0) && (ra2 == '0);

    always_comb begin
        regs_d = regs_q;
        if (we3 && !wa_zero) begin
            regs_d[wa3] = wd3;
        end
    end

    // Reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-through: reads see the stored value until the edge.
    assign rd1 = ra1_zero ? '0 : regs_q[ra1];
    assign rd2 = ra2_zero ? '0 : regs_q[ra2];

endmodule

// File: tb/tb_register_file.sv
// Directed and randomized self-checking bench for register_file,
// compared against an array-based reference model.
module tb_register_file;

    logic       clk;
    logic       rst;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] rd1;
    logic [7:0] rd2;

    int checks = 0;
    int errors = 0;

    logic [7:0] m [8];

    register_file dut (
        .clk (clk),
        .rst (rst),
        .we3 (we3),
        .wa3 (wa3),
        .wd3 (wd3),
        .ra1 (ra1),
        .ra2 (ra2),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mread(input logic [2:0] a);
        return (a == 3'd0) ? 8'h00 : m[a];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, updating the model with the inputs held across it.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) m[i] = 8'h00;
        end else if (we3 && wa3 != 3'd0) begin
            m[wa3] = wd3;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < 8; r++) begin
            ra1 = r[2:0];
            ra2 = 3'(7 - r);
            #1;
            check(tag, rd1, mread(ra1));
            check(tag, rd2, mread(ra2));
        end
    endtask

    initial begin
        rst = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
        tick();
        check_all("reset_init");

        rst = 1'b0; we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h07; ra1 = 3'd2;
        tick();
        check("pre_reset_w2", rd1, 8'h07);
        rst = 1'b1;
        tick();
        check("reset_r2", rd1, 8'h00);
        check_all("reset_all");

        rst = 1'b0; we3 = 1'b1; wa3 = 3'd1; wd3 = 8'hCA; ra2 = 3'd1;
        #1;
        check("w1_pre", rd2, 8'h00);
        tick();
        check("w1_post", rd2, 8'hCA);
        wa3 = 3'd7; wd3 = 8'hFE; ra1 = 3'd7;
        tick();
        check("w7_post", rd1, 8'hFE);

        we3 = 1'b0; wa3 = 3'd2; wd3 = 8'h34; ra1 = 3'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("we_off", rd1, 8'h00);
        end
        we3 = 1'b1;
        tick();
        check("we_on", rd1, 8'h34);

        wa3 = 3'd0; wd3 = 8'hDB; ra2 = 3'd0;
        #1;
        check("zero_pre", rd2, 8'h00);
        tick();
        check("zero_post", rd2, 8'h00);

        wa3 = 3'd5; wd3 = 8'h29; ra1 = 3'd5; ra2 = 3'd5;
        #1;
        check("dual_pre1", rd1, 8'h00);
        check("dual_pre2", rd2, 8'h00);
        tick();
        check("dual_post1", rd1, 8'h29);
        check("dual_post2", rd2, 8'h29);

        rst = 1'b1; wa3 = 3'd3; wd3 = 8'h11; ra1 = 3'd3;
        tick();
        check("rst_vs_write", rd1, 8'h00);
        rst = 1'b0;

        wa3 = 3'd1; wd3 = 8'hCA;
        tick();
        wa3 = 3'd7; wd3 = 8'hFE;
        tick();
        we3 = 1'b0;
        ra1 = 3'd1; #1;
        check("async_1a", rd1, 8'hCA);
        ra1 = 3'd7; #1;
        check("async_7", rd1, 8'hFE);
        ra1 = 3'd1; #1;
        check("async_1b", rd1, 8'hCA);

        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 31) == 0);
            we3 = $urandom_range(0, 3) != 0;
            wa3 = 3'($urandom);
            wd3 = 8'($urandom);
            ra1 = 3'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? wa3 : 3'($urandom);
            #1;
            check("rand_pre1", rd1, mread(ra1));
            check("rand_pre2", rd2, mread(ra2));
            tick();
            check("rand_post1", rd1, mread(ra1));
            check("rand_post2", rd2, mread(ra2));
        end
        rst = 1'b0; we3 = 1'b0;
        check_all("final_sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Multi-port general-purpose register file for the single-cycle RISC-V style datapath.
- Two asynchronous read ports feed the ALU operands; one synchronous write port takes the writeback result.
- Register 0 is hardwired to zero, following the RISC-V x0 convention.
- Default configuration: 8 registers × 8 bits.

Parameters:
- DATA_WIDTH, 8, width of each register and of the data ports.
- ADDR_WIDTH, 3, address width; the register count is 2**ADDR_WIDTH (8).
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- we3  in  1  write enable for the write port.
- wa3  in  ADDR_WIDTH  write address.
- wd3  in  DATA_WIDTH  write data.
- ra1  in  ADDR_WIDTH  read address, port 1.
- ra2  in  ADDR_WIDTH  read address, port 2.
- rd1  out  DATA_WIDTH  read data, port 1.
- rd2  out  DATA_WIDTH  read data, port 2.

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits each.
- Reset:
  - Applies on a rising clk edge with rst=1; every register clears to 0.
  - Reset has priority over a simultaneous write; the write is discarded.
  - Asserting rst only takes effect at the next rising edge (synchronous).
- Write:
  - On a rising clk edge with rst=0 and we3=1, reg[wa3] <= wd3.
  - With we3=0, no register changes.
  - Only one register is written per cycle.
- Read:
  - Purely combinational: rd1 = reg[ra1], rd2 = reg[ra2].
  - Read data updates immediately when an address or stored value changes; there is no clock latency.
- Write-read collision: when wa3 equals ra1 or ra2 during a write cycle, the read port shows the old value until the edge and the new value after it. There is no write-through bypass.
- Both read ports may address the same register simultaneously and return identical data.
- Zero register (ZERO_REG=1):
  - Reading address 0 on either port returns 0 at all times.
  - Writes to address 0 are accepted but have no effect.
- Before the first reset the register contents are undefined. Verification must apply reset before checking any read data.
- Arithmetic: none. Addresses are unsigned, and every address value is valid, so there is no out-of-range case.

Test Plan:
- Reset: write 8'h07 to reg 2, then hold rst=1 with we3=1 for one edge. Required: reg 2 reads 8'h00, and rd1 with ra1=2 reads 8'h00. Repeat for all 8 registers; all read 0.
- Basic write/read: rst=0, we3=1, wa3=1, wd3=8'hCA, ra2=1.
  - Required: rd2=8'h00 before the edge and 8'hCA after it.
  - Then wa3=7, wd3=8'hFE, ra1=7 → rd1=8'hFE after the edge.
- Write disable: we3=0, wa3=2, wd3=8'h34, ra1=2, across several edges. Required: rd1 holds its previous value (8'h00); then set we3=1 → rd1=8'h34 after the next edge.
- Zero register: we3=1, wa3=0, wd3=8'hDB, ra2=0. Required: rd2=8'h00 before and after the edge.
- Dual read and collision:
  - Write 8'h29 to reg 5 with ra1=5 and ra2=5. Required: both ports show the old value pre-edge and 8'h29 post-edge.
  - Write 8'h11 to reg 3 in the same cycle that rst=1. Required: reg 3 = 8'h00.
- Asynchronous read: with stable register contents, change ra1 mid-cycle between 1 and 7. Required: rd1 switches between 8'hCA and 8'hFE immediately, with no clock edge.
